multiport_ram_driver: RTL and testbench

- Generalised successor of the per-memory RAM drivers: one inferred simple-dual-port RAM shared by NUM_READERS read clients and one write client.
- Round-robin arbitration grants at most one read per cycle into a tagged read pipeline of configurable latency.
- Read data is returned to the originating client, and a read_ready strobe is raised only for that client.
- Replaces per-consumer RAM drivers in the video cache and packet buffer paths when several consumers share one memory.

---
 rtl/multiport_ram_driver_pkg.sv | 12 +
 rtl/multiport_ram_driver_tagged_delay.sv | 25 ++
 rtl/multiport_ram_driver.sv | 71 +++++++
 tb/tb_multiport_ram_driver.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/multiport_ram_driver_pkg.sv
// multiport_ram_driver_pkg: shared widths, instance defaults and clog2 helper for the RAM drivers.
package multiport_ram_driver_pkg;
    localparam int BYTE_LEN = 8;
    localparam int VIDEO_RAM_SIZE = 2048;
    localparam int VIDEO_LATENCY = 2;
    localparam int DEFAULT_READERS = 4;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/multiport_ram_driver_tagged_delay.sv
// tagged_delay: valid+tag shift register; the tag carries the reader index alongside read data.
module tagged_delay #(
    parameter int DELAY_LEN = 2,
    parameter int TAG_LEN = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [TAG_LEN-1:0] in_tag,
    output logic               out_valid,
    output logic [TAG_LEN-1:0] out_tag
);
    logic [DELAY_LEN-1:0] valid;
    logic [TAG_LEN-1:0]   tag [DELAY_LEN];
    always_ff @(posedge clk) begin
        valid[0] <= reset ? 1'b0 : in_valid;
        tag[0]   <= reset ? '0 : in_tag;
        for (int i = 1; i < DELAY_LEN; i++) begin
            valid[i] <= reset ? 1'b0 : valid[i-1];
            tag[i]   <= reset ? '0 : tag[i-1];
        end
    end
    assign out_valid = valid[DELAY_LEN-1];
    assign out_tag   = tag[DELAY_LEN-1];
endmodule

// File: rtl/multiport_ram_driver.sv
// multiport_ram_driver: one simple-dual-port RAM shared by NUM_READERS round-robin read clients and one writer.
module multiport_ram_driver
    import multiport_ram_driver_pkg::*;
#(
    parameter int DATA_WIDTH = BYTE_LEN,
    parameter int RAM_SIZE = VIDEO_RAM_SIZE,
    parameter int READ_LATENCY = VIDEO_LATENCY,
    parameter int NUM_READERS = DEFAULT_READERS,
    localparam int ADDR_LEN = clog2(RAM_SIZE)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_READERS-1:0]          read_req,
    input  logic [NUM_READERS*ADDR_LEN-1:0] read_addr,
    output logic [NUM_READERS-1:0]          read_grant,
    input  logic                            write_enable,
    input  logic [ADDR_LEN-1:0]             write_addr,
    input  logic [DATA_WIDTH-1:0]           write_val,
    output logic [NUM_READERS-1:0]          read_ready,
    output logic [DATA_WIDTH-1:0]           read_out
);
    localparam int TAG_LEN = NUM_READERS > 1 ? clog2(NUM_READERS) : 1;
    localparam logic [ADDR_LEN:0] LIMIT = (ADDR_LEN + 1)'(RAM_SIZE);
    logic [TAG_LEN-1:0]    rr_ptr, grant_idx, cand, out_tag;
    logic                  grant_any, out_valid;
    logic [ADDR_LEN-1:0]   addr;
    logic [DATA_WIDTH-1:0] mem [RAM_SIZE];
    logic [DATA_WIDTH-1:0] pipe [READ_LATENCY];
    // Scan candidates from farthest to nearest so the nearest requester after rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand = '0;
        for (int k = NUM_READERS; k >= 1; k--) begin
            cand = TAG_LEN'((int'(rr_ptr) + k) % NUM_READERS);
            if (read_req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (reset) grant_any = 1'b0;
    end
    assign read_grant = grant_any ? NUM_READERS'(1) << grant_idx : '0;
    assign addr = read_addr[grant_idx*ADDR_LEN +: ADDR_LEN];
    always_ff @(posedge clk) begin
        if (reset) rr_ptr <= TAG_LEN'(NUM_READERS - 1);
        else if (grant_any) rr_ptr <= grant_idx;
    end
    always_ff @(posedge clk) begin
        if (write_enable && {1'b0, write_addr} < LIMIT) mem[write_addr] <= write_val;
    end
    // pipe[0] is the RAM output register; read-first because the write lands on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else begin
            if (grant_any) pipe[0] <= ({1'b0, addr} < LIMIT) ? mem[addr] : '0;
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end
    tagged_delay #(.DELAY_LEN(READ_LATENCY), .TAG_LEN(TAG_LEN)) u_delay (
        .clk(clk),
        .reset(reset),
        .in_valid(grant_any),
        .in_tag(grant_idx),
        .out_valid(out_valid),
        .out_tag(out_tag)
    );
    assign read_ready = (out_valid && !reset) ? NUM_READERS'(1) << out_tag : '0;
    assign read_out = pipe[READ_LATENCY-1];
endmodule

// File: tb/tb_multiport_ram_driver.sv
// tb_multiport_ram_driver: directed and random reads/writes checked against a queue-based memory model.
module tb_multiport_ram_driver;
    localparam int DW = 8, RS = 1000, L = 2, N = 4, AL = 10;
    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  read_req, read_grant, read_ready;
    logic [N*AL-1:0] read_addr;
    logic          write_enable;
    logic [AL-1:0] write_addr;
    logic [DW-1:0] write_val, read_out;
    typedef struct { int due; int tag; logic [DW-1:0] data; } rd_t;
    rd_t           pend[$];
    logic [DW-1:0] seen[$];
    logic [DW-1:0] m_mem [1024];
    int            m_rr, cyc_n, n_cmp, n_err;
    bit            hold;
    always #5 clk = ~clk;
    multiport_ram_driver #(.DATA_WIDTH(DW), .RAM_SIZE(RS), .READ_LATENCY(L), .NUM_READERS(N)) dut (
        .clk(clk), .reset(reset), .read_req(read_req), .read_addr(read_addr),
        .read_grant(read_grant), .write_enable(write_enable), .write_addr(write_addr),
        .write_val(write_val), .read_ready(read_ready), .read_out(read_out)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic req(input int i, input int a);
        read_req[i] = 1'b1;
        read_addr[i*AL +: AL] = AL'(a);
    endtask
    task automatic wr(input int a, input int v);
        write_enable = 1'b1;
        write_addr = AL'(a);
        write_val = DW'(v);
    endtask
    // One clock: check grant/ready/data at the falling edge, then advance the model and the clock.
    task automatic cyc();
        logic [N-1:0]  eg, er, drop;
        logic [DW-1:0] ed;
        int g;
        @(negedge clk);
        g = -1;
        if (!reset) for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (g < 0 && read_req[c]) g = c;
        end
        eg = (g < 0) ? '0 : N'(1) << g;
        chk("grant", 32'(read_grant), 32'(eg));
        er = '0;
        ed = '0;
        if (reset) pend.delete();
        else if (pend.size() > 0 && pend[0].due == cyc_n) begin
            rd_t e;
            e = pend.pop_front();
            er = N'(1) << e.tag;
            ed = e.data;
        end
        chk("ready", 32'(read_ready), 32'(er));
        if (er != 0) begin
            chk("data", 32'(read_out), 32'(ed));
            seen.push_back(read_out);
        end
        drop = '0;
        if (g >= 0) begin
            int a;
            a = int'(read_addr[g*AL +: AL]);
            pend.push_back('{cyc_n + L, g, (a < RS) ? m_mem[a] : '0});
            m_rr = g;
            if (!hold) drop[g] = 1'b1;
        end
        if (reset) m_rr = N - 1;
        if (write_enable && int'(write_addr) < RS) m_mem[write_addr] = write_val;
        @(posedge clk);
        #1;
        read_req = read_req & ~drop;
        cyc_n++;
    endtask
    initial begin
        n_cmp = 0; n_err = 0; cyc_n = 0; m_rr = N - 1; hold = 1'b0;
        for (int a = 0; a < 1024; a++) m_mem[a] = '0;
        reset = 1'b1; read_req = '1; read_addr = '0; write_enable = 1'b0; write_addr = '0; write_val = '0;
        cyc(); cyc();
        chk("rst_out", 32'(read_out), 32'h0);
        reset = 1'b0; read_req = '0;
        for (int a = 0; a < RS; a++) begin wr(a, int'($urandom_range(0, 255))); cyc(); end
        write_enable = 1'b0;
        // reader 0 alone
        wr(5, 'h3C); cyc(); write_enable = 1'b0;
        req(0, 5);
        #1 chk("t1_grant", 32'(read_grant), 32'b0001);
        repeat (4) cyc();
        chk("t1_data", 32'(seen[$]), 32'h3C);
        // all four readers, one grant each in order
        reset = 1'b1; cyc(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin wr(i, 'h10 + i); cyc(); end
        write_enable = 1'b0;
        for (int i = 0; i < 4; i++) req(i, i);
        repeat (8) cyc();
        for (int i = 0; i < 4; i++) chk("t2_order", 32'(seen[seen.size() - 4 + i]), 32'h10 + i);
        // readers 1 and 3 held continuously from reset release
        reset = 1'b1; cyc(); reset = 1'b0;
        hold = 1'b1; req(1, 20); req(3, 21);
        #1 chk("t3_first", 32'(read_grant), 32'b0010);
        repeat (6) cyc();
        hold = 1'b0; read_req = '0;
        repeat (3) cyc();
        // read-first collision
        wr(7, 'hAA); cyc();
        wr(7, 'h55); req(0, 7); cyc();
        write_enable = 1'b0; req(0, 7);
        repeat (4) cyc();
        chk("t4_old", 32'(seen[seen.size() - 2]), 32'hAA);
        chk("t4_new", 32'(seen[$]), 32'h55);
        // reset kills reads in flight and restores reader 0 priority
        req(0, 30); cyc();
        req(1, 31); cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        for (int i = 0; i < 4; i++) req(i, 40 + i);
        #1 chk("t5_rr", 32'(read_grant), 32'b0001);
        repeat (8) cyc();
        // out-of-range read and write
        req(2, 1010); cyc();
        wr(1010, 'hFF); cyc();
        write_enable = 1'b0; req(2, 10);
        repeat (4) cyc();
        chk("t6_oor", 32'(seen[seen.size() - 2]), 32'h0);
        chk("t6_keep", 32'(seen[$]), 32'(m_mem[10]));
        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++)
                if (!read_req[i] && $urandom_range(0, 1) == 1) req(i, int'($urandom_range(0, 1023)));
            wr(int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)));
            write_enable = ($urandom_range(0, 1) == 1);
            reset = ($urandom_range(0, 49) == 0);
            cyc();
        end
        reset = 1'b0; read_req = '0; write_enable = 1'b0;
        repeat (4) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
